xilinx_fifo_sync_reader: RTL and testbench



---
 rtl/xilinx_fifo_pkg.sv | 20 ++
 rtl/xilinx_fifo_reader_buf.sv | 82 ++++++++
 rtl/xilinx_fifo_sync_reader.sv | 79 +++++++
 tb/tb_xilinx_fifo_sync_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xilinx_fifo_pkg.sv
// Shared constants and helpers for the block-RAM FIFO wrapper and its read-side adapter.
package xilinx_fifo_pkg;

    localparam int MAX_DATA_WIDTH = 32'd72;

    typedef struct packed {
        logic push;
        logic pop;
    } reader_buf_op_t;

    function automatic int read_latency(input int do_reg);
        return do_reg + 32'd1;
    endfunction

    // Room for every in-flight read plus one word being consumed and one waiting.
    function automatic int reader_buf_depth(input int do_reg);
        return do_reg + 32'd3;
    endfunction

endpackage

// File: rtl/xilinx_fifo_reader_buf.sv
// Small circular skid buffer holding words returned by the FIFO until the stream consumer takes them.
module xilinx_fifo_reader_buf
    import xilinx_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 32'd36,
    parameter  int DEPTH      = 32'd3,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH + 32'd1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  reader_buf_op_t        op,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [CNT_W-1:0]      occ,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]      occ_d, occ_q;
    logic                  do_pop_s;

    // Pointer wrap and occupancy bookkeeping.
    always_comb begin
        do_pop_s = op.pop && (occ_q != {CNT_W{1'b0}});

        if (!op.push) begin
            wr_ptr_d = wr_ptr_q;
        end else if (wr_ptr_q == PTR_W'(DEPTH - 32'd1)) begin
            wr_ptr_d = {PTR_W{1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        end

        if (!do_pop_s) begin
            rd_ptr_d = rd_ptr_q;
        end else if (rd_ptr_q == PTR_W'(DEPTH - 32'd1)) begin
            rd_ptr_d = {PTR_W{1'b0}};
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end

        case ({op.push, do_pop_s})
            2'b10:   occ_d = occ_q + CNT_W'(1'b1);
            2'b01:   occ_d = occ_q - CNT_W'(1'b1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            occ_q    <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is cleared on reset so a flushed adapter presents all-zero data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (op.push) begin
            mem_q[wr_ptr_q] <= push_data;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign occ     = occ_q;
    assign valid   = (occ_q != {CNT_W{1'b0}});
    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/xilinx_fifo_sync_reader.sv
// Read-side adapter for the synchronous block-RAM FIFO: credit-based RDEN issue, latency
// tracking tag pipeline and a skid buffer presenting a valid/ready stream.
module xilinx_fifo_sync_reader
    import xilinx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32'd36,
    parameter int DO_REG     = 32'd0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FIFO_EMPTY,
    input  logic                  FIFO_RDERR,
    input  logic [DATA_WIDTH-1:0] FIFO_DO,
    output logic                  FIFO_RDEN,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  ERR
);

    localparam int LAT       = read_latency(DO_REG);
    localparam int BUF_DEPTH = reader_buf_depth(DO_REG);
    localparam int CNT_W     = $clog2(BUF_DEPTH + 32'd1);
    localparam int SUM_W     = CNT_W + 32'd1;

    logic [LAT-1:0]   inflight_d, inflight_q;
    logic             err_d, err_q;
    logic [CNT_W-1:0] occ_s;
    logic [SUM_W-1:0] n_inflight_s;
    logic [SUM_W-1:0] credit_used_s;
    logic             rden_s;
    logic             valid_s;
    reader_buf_op_t   op_s;

    // Issue decision uses only registered credit state and EMPTY, so M_READY never reaches RDEN.
    always_comb begin
        n_inflight_s  = SUM_W'($countones(inflight_q));
        credit_used_s = SUM_W'(occ_s) + n_inflight_s;
        if (!FIFO_EMPTY && !RST && (credit_used_s < SUM_W'(BUF_DEPTH))) begin
            rden_s = 1'b1;
        end else begin
            rden_s = 1'b0;
        end

        inflight_d = LAT'({inflight_q, rden_s});
        err_d      = err_q | FIFO_RDERR;
        op_s.push  = inflight_q[LAT-1];
        op_s.pop   = valid_s & M_READY;
    end

    // Tag pipeline and sticky error flag; reset drops every outstanding tag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight_q <= {LAT{1'b0}};
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    xilinx_fifo_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .CLK       (CLK),
        .RST       (RST),
        .op        (op_s),
        .push_data (FIFO_DO),
        .occ       (occ_s),
        .valid     (valid_s),
        .rd_data   (M_DATA)
    );

    assign FIFO_RDEN = rden_s;
    assign M_VALID   = valid_s;
    assign ERR       = err_q;

endmodule

// File: tb/tb_xilinx_fifo_sync_reader.sv
// Bench for xilinx_fifo_sync_reader: two instances (DO_REG=0 and DO_REG=1), each fed by a
// behavioural FIFO model, with a scoreboard queue and handshake monitor per instance.
`timescale 1ns/1ps
module tb_xilinx_fifo_sync_reader;

    localparam int DW = 36;

    logic clk = 1'b0;
    logic rst;
    logic force_ne;

    logic          empty0, rderr0, rden0, valid0, ready0, err0, rderr_tb0, rderr_m0;
    logic [DW-1:0] do0, data0, do0_a;
    logic          empty1, rderr1, rden1, valid1, ready1, err1, rderr_tb1, rderr_m1;
    logic [DW-1:0] do1, data1, do1_a, do1_b;

    logic [DW-1:0] mem0 [0:1023];
    logic [DW-1:0] mem1 [0:1023];
    int wcnt0, rcnt0, wcnt1, rcnt1;
    logic em0, em1;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int n_chk;
    int n_pass;

    always #5 clk = ~clk;

    xilinx_fifo_sync_reader #(.DATA_WIDTH(DW), .DO_REG(0)) u_dut0 (
        .CLK(clk), .RST(rst), .FIFO_EMPTY(empty0), .FIFO_RDERR(rderr0), .FIFO_DO(do0),
        .FIFO_RDEN(rden0), .M_VALID(valid0), .M_READY(ready0), .M_DATA(data0), .ERR(err0));

    xilinx_fifo_sync_reader #(.DATA_WIDTH(DW), .DO_REG(1)) u_dut1 (
        .CLK(clk), .RST(rst), .FIFO_EMPTY(empty1), .FIFO_RDERR(rderr1), .FIFO_DO(do1),
        .FIFO_RDEN(rden1), .M_VALID(valid1), .M_READY(ready1), .M_DATA(data1), .ERR(err1));

    // FIFO models: EMPTY updates on the edge that consumes the last word; reset flushes.
    assign em0    = (rcnt0 == wcnt0);
    assign em1    = (rcnt1 == wcnt1);
    assign empty0 = em0 && !force_ne;
    assign empty1 = em1 && !force_ne;
    assign do0    = do0_a;
    assign do1    = do1_b;
    assign rderr0 = rderr_m0 | rderr_tb0;
    assign rderr1 = rderr_m1 | rderr_tb1;

    always @(posedge clk) begin
        if (rst) begin
            rcnt0    <= wcnt0;
            do0_a    <= '0;
            rderr_m0 <= 1'b0;
        end else begin
            rderr_m0 <= rden0 && em0;
            if (rden0 && !em0) begin
                do0_a <= mem0[rcnt0];
                rcnt0 <= rcnt0 + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            rcnt1    <= wcnt1;
            do1_a    <= '0;
            do1_b    <= '0;
            rderr_m1 <= 1'b0;
        end else begin
            rderr_m1 <= rden1 && em1;
            do1_b    <= do1_a;
            if (rden1 && !em1) begin
                do1_a <= mem1[rcnt1];
                rcnt1 <= rcnt1 + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input int k, input logic [DW-1:0] d);
        if (k == 0) begin
            mem0[wcnt0] = d;
            wcnt0++;
        end else begin
            mem1[wcnt1] = d;
            wcnt1++;
        end
    endtask

    // Scoreboard monitors: every accepted word must be the next expected one.
    always @(negedge clk) begin
        if (!rst && valid0 && ready0) begin
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL mon0_unexpected: got %0h, required no word", data0);
            end else begin
                chk("mon0_data", 64'(data0), 64'(q0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid1 && ready1) begin
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL mon1_unexpected: got %0h, required no word", data1);
            end else begin
                chk("mon1_data", 64'(data1), 64'(q1.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int gaps;
        int issued;
        int accepted;
        int max_out;
        int unstable;
        int stale;
        int cyc;
        logic have_prev;
        logic [DW-1:0] prev_d;

        n_chk = 0; n_pass = 0;
        rst = 1'b1; force_ne = 1'b1;
        ready0 = 1'b0; ready1 = 1'b0;
        rderr_tb0 = 1'b0; rderr_tb1 = 1'b0;

        // Reset held two cycles with the FIFO claiming data.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_rden0", 64'(rden0), 64'd0);
            chk("rst_valid0", 64'(valid0), 64'd0);
            chk("rst_err0", 64'(err0), 64'd0);
            chk("rst_data0", 64'(data0), 64'd0);
            chk("rst_rden1", 64'(rden1), 64'd0);
            chk("rst_valid1", 64'(valid1), 64'd0);
            chk("rst_err1", 64'(err1), 64'd0);
            chk("rst_data1", 64'(data1), 64'd0);
        end
        tick();
        rst = 1'b0; force_ne = 1'b0;
        @(negedge clk);
        chk("post_rst_valid0", 64'(valid0), 64'd0);
        chk("post_rst_valid1", 64'(valid1), 64'd0);

        // Sticky error.
        tick();
        rderr_tb0 = 1'b1;
        @(negedge clk);
        chk("err_not_yet", 64'(err0), 64'd0);
        tick();
        rderr_tb0 = 1'b0;
        @(negedge clk);
        chk("err_set", 64'(err0), 64'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("err_sticky", 64'(err0), 64'd1);
        chk("err_other_inst", 64'(err1), 64'd0);

        // First-word latency, DO_REG=1.
        tick();
        ready1 = 1'b1;
        fifo_write(1, 36'h11);
        q1.push_back(36'h11);
        @(negedge clk);
        chk("lat_rden", 64'(rden1), 64'd1);
        @(negedge clk);
        lat = 1;
        chk("lat_empty_back", 64'(empty1), 64'd1);
        chk("lat_rden_off", 64'(rden1), 64'd0);
        while (!valid1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("lat_cycles", 64'(lat), 64'd3);
        @(negedge clk);
        chk("lat_drained", 64'(valid1), 64'd0);

        // Throughput, DO_REG=0: 256 words back to back.
        tick();
        ready0 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem0[wcnt0 + i] = DW'(i);
            q0.push_back(DW'(i));
        end
        wcnt0 += 256;
        @(negedge clk);
        chk("thru_rden", 64'(rden0), 64'd1);
        lat = 0;
        while (!valid0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("thru_first_lat", 64'(lat), 64'd2);
        gaps = 0;
        for (int i = 0; i < 256; i++) begin
            if (!valid0) gaps++;
            @(negedge clk);
        end
        chk("thru_gaps", 64'(gaps), 64'd0);
        chk("thru_end_valid", 64'(valid0), 64'd0);
        chk("thru_all_seen", 64'(q0.size()), 64'd0);

        // Backpressure, DO_REG=1: stall first so credits run out, then ~30% ready.
        tick();
        ready1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fifo_write(1, DW'(i));
            q1.push_back(DW'(i));
        end
        issued = 0; accepted = 0; max_out = 0; unstable = 0; cyc = 0;
        have_prev = 1'b0; prev_d = '0;
        while (accepted < 16 && cyc < 600) begin
            @(negedge clk);
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (have_prev && (!valid1 || data1 !== prev_d)) unstable++;
            have_prev = valid1 && !ready1;
            prev_d = data1;
            if (rden1) issued++;
            if (valid1 && ready1) accepted++;
            cyc++;
            tick();
            if (cyc < 6) ready1 = 1'b0;
            else if (cyc > 400) ready1 = 1'b1;
            else ready1 = ($urandom_range(0, 9) < 3);
        end
        ready1 = 1'b0;
        chk("bp_delivered", 64'(accepted), 64'd16);
        chk("bp_issued", 64'(issued), 64'd16);
        chk("bp_max_outstanding", 64'(max_out), 64'd4);
        chk("bp_stall_stable", 64'(unstable), 64'd0);
        chk("bp_queue_empty", 64'(q1.size()), 64'd0);
        chk("bp_no_rderr", 64'(err1), 64'd0);

        // Reset with two words buffered and two reads in flight.
        tick();
        for (int i = 0; i < 8; i++) fifo_write(1, DW'(32'hA0 + i));
        repeat (4) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_pre_valid", 64'(valid1), 64'd1);
        chk("mid_pre_data", 64'(data1), 64'hA0);
        chk("mid_rden_in_rst", 64'(rden1), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_valid_low", 64'(valid1), 64'd0);
        chk("mid_data_clear", 64'(data1), 64'd0);
        chk("mid_err_cleared", 64'(err0), 64'd0);
        tick();
        ready1 = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid1) stale++;
        end
        chk("mid_no_stale", 64'(stale), 64'd0);
        tick();
        fifo_write(1, 36'h5A5);
        q1.push_back(36'h5A5);
        lat = 0;
        @(negedge clk);
        while (!valid1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("mid_fresh_lat", 64'(lat), 64'd3);
        repeat (3) @(negedge clk);
        chk("final_q0_empty", 64'(q0.size()), 64'd0);
        chk("final_q1_empty", 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
